iq_carrier_buffer: RTL

- Sits directly downstream of the QPSK IQ mapper.
- Collects mapped I/Q carrier samples (xr/xi with their valid strobe) into a two-bank ping-pong RAM, one OFDM symbol's worth of data carriers per bank.
- Streams each completed symbol to the IFFT stage as NFFT samples: data carriers first, then zero-valued null carriers, under a valid/ready handshake.
- Back-pressures the mapper via full when both banks are occupied.

---
 rtl/iq_carrier_buffer.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/iq_carrier_buffer.sv
// Ping-pong carrier buffer between the QPSK mapper and the IFFT: it stores NCAR data
// carriers per bank and emits NFFT samples per symbol. IQ_CARRIER_BUFFER_STATUS_EN adds the ovf/fill status ports.
module iq_carrier_buffer #(
    parameter int unsigned DW   = 11,
    parameter int unsigned NCAR = 96,
    parameter int unsigned NFFT = 128,
    parameter int unsigned AW   = 7
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          ce,
    input  logic          valid_i,
    input  logic [DW-1:0] xr_i,
    input  logic [DW-1:0] xi_i,
    output logic          full,
    input  logic          ready_i,
    output logic [DW-1:0] yr,
    output logic [DW-1:0] yi,
    output logic          valid_o,
    output logic          sop,
    output logic          eop
`ifdef IQ_CARRIER_BUFFER_STATUS_EN
    ,
    output logic          ovf,
    output logic [1:0]    fill
`endif
);

    localparam logic [AW-1:0] WLAST  = AW'(NCAR - 1);
    localparam logic [AW-1:0] RLAST  = AW'(NFFT - 1);
    localparam logic [AW:0]   NCAR_W = (AW + 1)'(NCAR);
    localparam logic [AW:0]   RLAST_W = (AW + 1)'(NFFT - 1);

    typedef enum logic [1:0] {IDLE, LOAD, STREAM} rstate_e;

    logic [DW-1:0] mem_r [2][NCAR];
    logic [DW-1:0] mem_i [2][NCAR];

    logic [AW-1:0] wcnt_q, wcnt_d;
    logic          wbank_q, wbank_d;
    logic [1:0]    filled_q, filled_d;
    logic          rbank_q;
    logic [AW-1:0] rcnt_q;
    rstate_e       state_q;

    logic          wr_en, wr_done, rd_release;
    logic [AW:0]   nidx;
    logic [DW-1:0] rd_r, rd_i;

    // Write side next state; read release and write completion always target different banks.
    always_comb begin
        wr_en      = ce & valid_i & ~full;
        wr_done    = wr_en & (wcnt_q == WLAST);
        rd_release = (state_q == STREAM) & valid_o & ready_i & (rcnt_q == RLAST);
        wcnt_d     = wcnt_q;
        wbank_d    = wbank_q;
        filled_d   = filled_q;
        if (wr_en) begin
            if (wr_done) begin
                wcnt_d  = '0;
                wbank_d = ~wbank_q;
            end else begin
                wcnt_d  = wcnt_q + 1'b1;
            end
        end
        if (rd_release) filled_d[rbank_q] = 1'b0;
        if (wr_done)    filled_d[wbank_q] = 1'b1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wcnt_q   <= '0;
            wbank_q  <= 1'b0;
            filled_q <= '0;
            full     <= 1'b0;
        end else begin
            wcnt_q   <= wcnt_d;
            wbank_q  <= wbank_d;
            filled_q <= filled_d;
            full     <= filled_d[wbank_d];
        end
    end

    // Sample storage; contents are don't-care after reset.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_r[wbank_q][wcnt_q] <= xr_i;
            mem_i[wbank_q][wcnt_q] <= xi_i;
        end
    end

    // Lookahead fetch: the sample presented after the next load or transfer.
    always_comb begin
        nidx = (state_q == LOAD) ? '0 : ({1'b0, rcnt_q} + (AW + 1)'(1));
        rd_r = '0;
        rd_i = '0;
        if (nidx < NCAR_W) begin
            rd_r = mem_r[rbank_q][nidx[AW-1:0]];
            rd_i = mem_i[rbank_q][nidx[AW-1:0]];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            rbank_q <= 1'b0;
            rcnt_q  <= '0;
            yr      <= '0;
            yi      <= '0;
            valid_o <= 1'b0;
            sop     <= 1'b0;
            eop     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (filled_q[rbank_q]) begin
                        state_q <= LOAD;
                        rcnt_q  <= '0;
                    end
                end
                LOAD: begin
                    state_q <= STREAM;
                    rcnt_q  <= '0;
                    yr      <= rd_r;
                    yi      <= rd_i;
                    valid_o <= 1'b1;
                    sop     <= 1'b1;
                    eop     <= (NFFT == 1);
                end
                STREAM: begin
                    if (valid_o & ready_i) begin
                        if (rcnt_q == RLAST) begin
                            state_q <= IDLE;
                            rcnt_q  <= '0;
                            rbank_q <= ~rbank_q;
                            valid_o <= 1'b0;
                            sop     <= 1'b0;
                            eop     <= 1'b0;
                        end else begin
                            rcnt_q  <= rcnt_q + 1'b1;
                            yr      <= rd_r;
                            yi      <= rd_i;
                            sop     <= 1'b0;
                            eop     <= (nidx == RLAST_W);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef IQ_CARRIER_BUFFER_STATUS_EN
    // Sticky drop indicator and occupied-bank count.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ovf  <= 1'b0;
            fill <= '0;
        end else begin
            ovf  <= ovf | (ce & valid_i & full);
            fill <= 2'(filled_d[0]) + 2'(filled_d[1]);
        end
    end
`endif

endmodule
